mod_tx_scheduler: RTL and testbench
===================================

MOD_TX_SCHEDULER -- requirements
Module: mod_tx_scheduler

Interface
REQ-001 Parameter FRAME_LEN, default 16: bytes per frame, legal range 1..256.
REQ-002 Parameter PRE_AMP, default 16'sd8192: preamble I amplitude; used only when the Configuration macro is defined.
REQ-003 Clocking: one clock; reset is synchronous and active-high.
REQ-004 clk  in  1  sole clock; all state updates on its rising edge.
REQ-005 reset  in  1  synchronous, active-high reset.
REQ-006 in_data  in  8  source byte.
REQ-007 in_valid  in  1  in_data is valid.
REQ-008 in_ready  out  1  scheduler can accept a byte.
REQ-009 mod_data  out  8  registered byte driven to the Modulation data_in port.
REQ-010 I_in1..I_in4  in  16 signed each  modulator I symbols 1..4.
REQ-011 Q_in1..Q_in4  in  16 signed each  modulator Q symbols 1..4.
REQ-012 sym_I, sym_Q  out  16 signed each  current serialized symbol.
REQ-013 sym_valid  out  1  sym_I/sym_Q/sym_first/sym_last are valid.
REQ-014 sym_ready  in  1  sink accepts the symbol.
REQ-015 sym_first  out  1  first symbol of a frame.
REQ-016 sym_last  out  1  last symbol of a frame.
REQ-017 byte_cnt  out  8  index of the byte within the frame, 0..FRAME_LEN-1.

Function
REQ-018 FSM states: IDLE, LOAD, PRE, SEND.
REQ-019 IDLE transitions:
- in_ready=1 only in IDLE.
- On in_valid&&in_ready, register in_data into mod_data and go to LOAD.
REQ-020 LOAD lasts exactly one cycle:
- Capture I_in1..4 and Q_in1..4 into internal symbol registers.
- Go to PRE if the macro is defined and byte_cnt==0; otherwise go to SEND with sym_idx=0.
REQ-021 SEND behaviour:
- sym_valid=1.
- sym_I/sym_Q = captured symbol[sym_idx], with symbol 1 at sym_idx 0.
- sym_idx advances only on sym_valid&&sym_ready.
REQ-022 Hold rule: while sym_valid=1 and sym_ready=0, sym_I, sym_Q, sym_first and sym_last stay stable.
REQ-023 End of byte (sym_idx==3 accepted):
- Go to IDLE.
- If byte_cnt==FRAME_LEN-1, byte_cnt wraps to 0; otherwise byte_cnt increments.
REQ-024 sym_first=1 only on the first symbol emitted for byte_cnt==0: the preamble symbol if the macro is defined, else data symbol 1.
REQ-025 sym_last=1 only on sym_idx==3 when byte_cnt==FRAME_LEN-1.
REQ-026 With FRAME_LEN==1, every byte is a complete frame, and sym_first and sym_last are asserted on that byte's first and last symbols respectively.
REQ-027 Latency: a byte accepted at edge N gives sym_valid=1 at cycle N+2 (macro off or byte_cnt!=0).
REQ-028 Throughput: peak rate is one byte per 6 cycles with sym_ready held high; there is no overlap between bytes.
REQ-029 mod_data changes only on byte acceptance, so the modulator inputs are stable through LOAD.
REQ-030 When sym_valid=0, sym_I and sym_Q are 0.

Reset
REQ-031 Reset takes priority over all other events, including mid-SEND, and discards any in-flight byte without emitting its remaining symbols.
REQ-032 Reset values:
- State=IDLE, sym_idx=0, byte_cnt=0.
- mod_data=0, symbol registers=0.
- sym_valid=0, sym_first=0, sym_last=0, sym_I=0, sym_Q=0.
- in_ready=0 while reset is high; in_ready=1 on the first cycle after reset.

Configuration
REQ-033 Macro MOD_SCHED_PREAMBLE_EN.
REQ-034 When MOD_SCHED_PREAMBLE_EN is defined:
- PRE emits 2 preamble symbols, I=PRE_AMP then I=-PRE_AMP, with Q=0 for both.
- Each preamble symbol uses the same valid/ready handshake as SEND.
- The first preamble symbol carries sym_first; PRE then goes to SEND with sym_idx=0.
- First-symbol latency for byte_cnt==0 is unchanged (N+2). That byte's first data symbol is delayed by 2 accepted handshakes.
REQ-035 When MOD_SCHED_PREAMBLE_EN is not defined, the PRE state and PRE_AMP logic are absent, and frames consist of data symbols only.

Verification
REQ-036 Reset then a single byte:
- Stimulus: reset 2 cycles, in_data=8'hA5 valid, stub I_in1..4=100,200,300,400 and Q_in1..4=-1,-2,-3,-4, sym_ready=1.
- Response: mod_data=A5; sym_valid from N+2 for 4 cycles with sym_I=100,200,300,400 and sym_Q=-1..-4; sym_first on symbol 1; byte_cnt goes to 1.
REQ-037 Backpressure:
- Stimulus: sym_ready=0 for 3 cycles during symbol 2.
- Response: sym_I=200 and sym_Q=-2 held stable; the next symbol is 300 only after sym_ready=1; in_ready stays 0.
REQ-038 Frame wrap:
- Stimulus: FRAME_LEN=4, send 5 bytes.
- Response: sym_last only on symbol 4 of byte 3; byte_cnt 3 wraps to 0; byte 4 carries sym_first.
REQ-039 Reset mid-SEND:
- Stimulus: assert reset after symbol 2 is accepted.
- Response: next cycle sym_valid=0, byte_cnt=0; the next byte starts a fresh frame with sym_first=1.
REQ-040 Preamble, macro defined:
- Stimulus: first byte of a frame, PRE_AMP=8192.
- Response: symbols (8192,0) with sym_first, then (-8192,0), then the 4 data symbols; the second byte has no preamble.
REQ-041 Loopback with the Modulation and Demodulation modules:
- Stimulus: all 256 byte values through the scheduler, modulator and demodulator, reassembling the 4 symbols per byte.
- Response: the demodulated byte equals the input byte for every value.

Source files
------------

// File: rtl/mod_tx_scheduler.sv
// -----------------------------------------------------------------------------
// mod_tx_scheduler
//
// Purpose:
//   Takes source bytes one at a time, presents each byte to a downstream
//   modulator through mod_data, captures the four I/Q symbols the modulator
//   produces, and serializes them onto a valid/ready symbol stream. The
//   stream is tagged with frame boundaries: sym_first and sym_last. A frame
//   is FRAME_LEN bytes long.
//
// Optional feature:
//   Define MOD_SCHED_PREAMBLE_EN to prefix every frame with two preamble
//   symbols, (PRE_AMP, 0) followed by (-PRE_AMP, 0). Without the macro the
//   preamble state and its datapath are not built.
//
// Ports:
//   clk                  sole clock, rising edge
//   reset                synchronous, active-high reset
//   in_data/in_valid     source byte and its qualifier
//   in_ready             high only in IDLE (and never while reset is high)
//   mod_data             registered byte driven to the modulator input
//   I_in1..4, Q_in1..4   modulator symbol outputs, captured during LOAD
//   sym_I/sym_Q          current serialized symbol (0 when sym_valid is 0)
//   sym_valid/sym_ready  symbol handshake
//   sym_first/sym_last   frame boundary markers
//   byte_cnt             index of the current byte within the frame
// -----------------------------------------------------------------------------
module mod_tx_scheduler #(
    parameter int unsigned        FRAME_LEN = 16,
    parameter logic signed [15:0] PRE_AMP   = 16'sd8192
) (
    input  logic               clk,
    input  logic               reset,
    input  logic        [7:0]  in_data,
    input  logic               in_valid,
    output logic               in_ready,
    output logic        [7:0]  mod_data,
    input  logic signed [15:0] I_in1,
    input  logic signed [15:0] I_in2,
    input  logic signed [15:0] I_in3,
    input  logic signed [15:0] I_in4,
    input  logic signed [15:0] Q_in1,
    input  logic signed [15:0] Q_in2,
    input  logic signed [15:0] Q_in3,
    input  logic signed [15:0] Q_in4,
    output logic signed [15:0] sym_I,
    output logic signed [15:0] sym_Q,
    output logic               sym_valid,
    input  logic               sym_ready,
    output logic               sym_first,
    output logic               sym_last,
    output logic        [7:0]  byte_cnt
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_LOAD = 2'd1;
`ifdef MOD_SCHED_PREAMBLE_EN
    localparam logic [1:0] ST_PRE  = 2'd2;
`endif
    localparam logic [1:0] ST_SEND = 2'd3;

    // FRAME_LEN is limited to 1..256, so the last index always fits in 8 bits.
    localparam logic [7:0] LAST_CNT = 8'(FRAME_LEN - 1);

    logic        [1:0]  r_state;
    logic        [1:0]  r_sym_idx;
    logic        [7:0]  r_byte_cnt;
    logic        [7:0]  r_mod_data;
    logic signed [15:0] r_sym_i [4];
    logic signed [15:0] r_sym_q [4];

    logic w_sym_accept;
    logic w_last_of_frame;
    logic w_first_in_send;

`ifdef MOD_SCHED_PREAMBLE_EN
    logic r_pre_idx;
`else
    // PRE_AMP has no function in this build; fold it into a dead signal.
    logic w_unused_pre_amp;
    assign w_unused_pre_amp = ^PRE_AMP;
`endif

    assign w_sym_accept    = sym_valid && sym_ready;
    assign w_last_of_frame = (r_byte_cnt == LAST_CNT);

`ifdef MOD_SCHED_PREAMBLE_EN
    // The preamble symbol carries sym_first, never data symbol 1.
    assign w_first_in_send = 1'b0;
`else
    assign w_first_in_send = (r_sym_idx == 2'd0) && (r_byte_cnt == 8'd0);
`endif

    // -------------------------------------------------------------------------
    // State, byte counter and capture registers
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= ST_IDLE;
            r_sym_idx  <= 2'd0;
            r_byte_cnt <= 8'd0;
            r_mod_data <= 8'd0;
            for (int k = 0; k < 4; k++) begin
                r_sym_i[k] <= 16'sd0;
                r_sym_q[k] <= 16'sd0;
            end
`ifdef MOD_SCHED_PREAMBLE_EN
            r_pre_idx  <= 1'b0;
`endif
        end else begin
            case (r_state)
                ST_IDLE: begin
                    // in_ready is high for the whole of IDLE outside reset.
                    if (in_valid) begin
                        r_mod_data <= in_data;
                        r_state    <= ST_LOAD;
                    end
                end

                ST_LOAD: begin
                    // mod_data has been stable for a full cycle, so the
                    // modulator outputs are settled here.
                    r_sym_i[0] <= I_in1;
                    r_sym_i[1] <= I_in2;
                    r_sym_i[2] <= I_in3;
                    r_sym_i[3] <= I_in4;
                    r_sym_q[0] <= Q_in1;
                    r_sym_q[1] <= Q_in2;
                    r_sym_q[2] <= Q_in3;
                    r_sym_q[3] <= Q_in4;
                    r_sym_idx  <= 2'd0;
`ifdef MOD_SCHED_PREAMBLE_EN
                    if (r_byte_cnt == 8'd0) begin
                        r_state   <= ST_PRE;
                        r_pre_idx <= 1'b0;
                    end else begin
                        r_state   <= ST_SEND;
                    end
`else
                    r_state    <= ST_SEND;
`endif
                end

`ifdef MOD_SCHED_PREAMBLE_EN
                ST_PRE: begin
                    if (w_sym_accept) begin
                        if (r_pre_idx) begin
                            r_pre_idx <= 1'b0;
                            r_state   <= ST_SEND;
                        end else begin
                            r_pre_idx <= 1'b1;
                        end
                    end
                end
`endif

                ST_SEND: begin
                    if (w_sym_accept) begin
                        if (r_sym_idx == 2'd3) begin
                            r_sym_idx <= 2'd0;
                            r_state   <= ST_IDLE;
                            if (w_last_of_frame) begin
                                r_byte_cnt <= 8'd0;
                            end else begin
                                r_byte_cnt <= r_byte_cnt + 8'd1;
                            end
                        end else begin
                            r_sym_idx <= r_sym_idx + 2'd1;
                        end
                    end
                end

                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    // -------------------------------------------------------------------------
    // Outputs: decoded from registered state only, so they cannot change while
    // a symbol is stalled by sym_ready=0.
    // -------------------------------------------------------------------------
    always_comb begin
        sym_valid = 1'b0;
        sym_I     = 16'sd0;
        sym_Q     = 16'sd0;
        sym_first = 1'b0;
        sym_last  = 1'b0;
        case (r_state)
            ST_SEND: begin
                sym_valid = 1'b1;
                sym_I     = r_sym_i[r_sym_idx];
                sym_Q     = r_sym_q[r_sym_idx];
                sym_first = w_first_in_send;
                sym_last  = (r_sym_idx == 2'd3) && w_last_of_frame;
            end
`ifdef MOD_SCHED_PREAMBLE_EN
            ST_PRE: begin
                // Only reached with byte_cnt==0, so the first preamble
                // symbol is always the frame start.
                sym_valid = 1'b1;
                sym_I     = r_pre_idx ? -PRE_AMP : PRE_AMP;
                sym_Q     = 16'sd0;
                sym_first = !r_pre_idx;
            end
`endif
            default: begin
            end
        endcase
    end

    assign in_ready = (r_state == ST_IDLE) && !reset;
    assign mod_data = r_mod_data;
    assign byte_cnt = r_byte_cnt;

endmodule

// File: tb/tb_mod_tx_scheduler.sv
// -----------------------------------------------------------------------------
// tb_mod_tx_scheduler
//
// Directed bench for mod_tx_scheduler built with FRAME_LEN=4. The modulator
// is replaced by stub symbol values derived from a per-byte offset, so each
// byte has its own distinct expected symbol pattern.
// -----------------------------------------------------------------------------
module tb_mod_tx_scheduler;

    logic               clk = 1'b0;
    logic               reset;
    logic        [7:0]  in_data;
    logic               in_valid;
    logic               in_ready;
    logic        [7:0]  mod_data;
    logic signed [15:0] I_in1, I_in2, I_in3, I_in4;
    logic signed [15:0] Q_in1, Q_in2, Q_in3, Q_in4;
    logic signed [15:0] sym_I, sym_Q;
    logic               sym_valid;
    logic               sym_ready;
    logic               sym_first;
    logic               sym_last;
    logic        [7:0]  byte_cnt;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    mod_tx_scheduler #(
        .FRAME_LEN (4),
        .PRE_AMP   (16'sd8192)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .mod_data  (mod_data),
        .I_in1     (I_in1),
        .I_in2     (I_in2),
        .I_in3     (I_in3),
        .I_in4     (I_in4),
        .Q_in1     (Q_in1),
        .Q_in2     (Q_in2),
        .Q_in3     (Q_in3),
        .Q_in4     (Q_in4),
        .sym_I     (sym_I),
        .sym_Q     (sym_Q),
        .sym_valid (sym_valid),
        .sym_ready (sym_ready),
        .sym_first (sym_first),
        .sym_last  (sym_last),
        .byte_cnt  (byte_cnt)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Stub modulator: I_k = 100*k + off, Q_k = -k - off.
    task automatic set_stubs(input int off);
        I_in1 = 16'(100 + off);
        I_in2 = 16'(200 + off);
        I_in3 = 16'(300 + off);
        I_in4 = 16'(400 + off);
        Q_in1 = 16'(-1 - off);
        Q_in2 = 16'(-2 - off);
        Q_in3 = 16'(-3 - off);
        Q_in4 = 16'(-4 - off);
    endtask

    task automatic chk_sym(input int s, input int off, input logic e_first, input logic e_last);
        logic [15:0] e_i;
        logic [15:0] e_q;
        e_i = 16'(100 * (s + 1) + off);
        e_q = 16'(-(s + 1) - off);
        chk($sformatf("sym%0d_valid", s), {31'd0, sym_valid}, 32'd1);
        chk($sformatf("sym%0d_I", s), {16'd0, sym_I}, {16'd0, e_i});
        chk($sformatf("sym%0d_Q", s), {16'd0, sym_Q}, {16'd0, e_q});
        chk($sformatf("sym%0d_first", s), {31'd0, sym_first}, {31'd0, e_first});
        chk($sformatf("sym%0d_last", s), {31'd0, sym_last}, {31'd0, e_last});
    endtask

    // Send one byte and check it end to end. stall_at selects the symbol held
    // off for 3 cycles with sym_ready=0 (-1 for none).
    task automatic run_byte(input logic [7:0] d, input logic exp_first, input logic exp_last,
                            input int stall_at, input int off, input logic [7:0] cnt_after);
        @(negedge clk);
        set_stubs(off);
        in_data  = d;
        in_valid = 1'b1;
        chk("idle_in_ready", {31'd0, in_ready}, 32'd1);
        @(negedge clk);
        in_valid = 1'b0;
        chk("load_mod_data", {24'd0, mod_data}, {24'd0, d});
        chk("load_sym_valid", {31'd0, sym_valid}, 32'd0);
        chk("load_in_ready", {31'd0, in_ready}, 32'd0);
`ifdef MOD_SCHED_PREAMBLE_EN
        if (exp_first) begin
            @(negedge clk);
            chk("pre0_valid", {31'd0, sym_valid}, 32'd1);
            chk("pre0_I", {16'd0, sym_I}, {16'd0, 16'sd8192});
            chk("pre0_Q", {16'd0, sym_Q}, 32'd0);
            chk("pre0_first", {31'd0, sym_first}, 32'd1);
            @(negedge clk);
            chk("pre1_valid", {31'd0, sym_valid}, 32'd1);
            chk("pre1_I", {16'd0, sym_I}, {16'd0, -16'sd8192});
            chk("pre1_Q", {16'd0, sym_Q}, 32'd0);
            chk("pre1_first", {31'd0, sym_first}, 32'd0);
        end
`endif
        for (int s = 0; s < 4; s++) begin
            logic e_first;
            e_first = 1'b0;
`ifndef MOD_SCHED_PREAMBLE_EN
            e_first = exp_first && (s == 0);
`endif
            @(negedge clk);
            if (s == stall_at) begin
                sym_ready = 1'b0;
                for (int h = 0; h < 3; h++) begin
                    chk_sym(s, off, e_first, exp_last && (s == 3));
                    chk("stall_in_ready", {31'd0, in_ready}, 32'd0);
                    @(negedge clk);
                end
                sym_ready = 1'b1;
            end
            chk_sym(s, off, e_first, exp_last && (s == 3));
            // Captured symbols must not follow the modulator after LOAD.
            if (s == 0) begin
                set_stubs(7777);
            end
        end
        @(negedge clk);
        chk("done_sym_valid", {31'd0, sym_valid}, 32'd0);
        chk("done_sym_I", {16'd0, sym_I}, 32'd0);
        chk("done_sym_Q", {16'd0, sym_Q}, 32'd0);
        chk("done_byte_cnt", {24'd0, byte_cnt}, {24'd0, cnt_after});
        chk("done_in_ready", {31'd0, in_ready}, 32'd1);
    endtask

    initial begin
        reset     = 1'b1;
        in_valid  = 1'b0;
        in_data   = 8'd0;
        sym_ready = 1'b1;
        set_stubs(0);

        // Reset state
        repeat (2) @(negedge clk);
        chk("rst_in_ready", {31'd0, in_ready}, 32'd0);
        chk("rst_sym_valid", {31'd0, sym_valid}, 32'd0);
        chk("rst_mod_data", {24'd0, mod_data}, 32'd0);
        chk("rst_byte_cnt", {24'd0, byte_cnt}, 32'd0);
        chk("rst_sym_I", {16'd0, sym_I}, 32'd0);
        chk("rst_sym_first", {31'd0, sym_first}, 32'd0);
        chk("rst_sym_last", {31'd0, sym_last}, 32'd0);
        reset = 1'b0;
        @(negedge clk);
        chk("post_rst_in_ready", {31'd0, in_ready}, 32'd1);

        // Single byte, then backpressure on symbol 2, then the rest of the frame
        run_byte(8'hA5, 1'b1, 1'b0, -1, 0, 8'd1);
        run_byte(8'h3C, 1'b0, 1'b0, 1, 0, 8'd2);
        run_byte(8'h5A, 1'b0, 1'b0, -1, 7, 8'd3);
        run_byte(8'hFF, 1'b0, 1'b1, -1, 11, 8'd0);
        // Fifth byte starts the next frame
        run_byte(8'h00, 1'b1, 1'b0, 3, 3, 8'd1);

        // Reset once symbol 2 of a mid-frame byte has been accepted
        @(negedge clk);
        set_stubs(5);
        in_data  = 8'h11;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        chk("mid_s0_I", {16'd0, sym_I}, 32'd105);
        @(negedge clk);
        chk("mid_s1_I", {16'd0, sym_I}, 32'd205);
        @(negedge clk);
        chk("mid_s2_I", {16'd0, sym_I}, 32'd305);
        reset = 1'b1;
        @(negedge clk);
        chk("mid_rst_sym_valid", {31'd0, sym_valid}, 32'd0);
        chk("mid_rst_sym_I", {16'd0, sym_I}, 32'd0);
        chk("mid_rst_byte_cnt", {24'd0, byte_cnt}, 32'd0);
        chk("mid_rst_mod_data", {24'd0, mod_data}, 32'd0);
        chk("mid_rst_in_ready", {31'd0, in_ready}, 32'd0);
        reset = 1'b0;
        @(negedge clk);
        chk("mid_post_in_ready", {31'd0, in_ready}, 32'd1);
        chk("mid_post_sym_valid", {31'd0, sym_valid}, 32'd0);
        run_byte(8'h22, 1'b1, 1'b0, -1, 9, 8'd1);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
